// File: rtl/gf233_pkg.sv
// Shared GF(2^233) definitions for the ECC datapath: field constants, element type
// and the fixed squaring map modulo x^233 + x^74 + 1.
package gf233_pkg;

    localparam int GF_M        = 233;
    localparam int GF_K        = 74;
    localparam int GF_SQRT_EXP = 232;

    typedef logic [GF_M-1:0] gf233_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sqrt_state_e;

    // Spread coefficients to even positions, then fold the top half down from the highest
    // degree, so terms that land at or above x^233 are reduced again.
    function automatic gf233_t gf233_sqr_f(input gf233_t a);
        logic [2*GF_M-2:0] t;
        t = '0;
        for (int i = 0; i < GF_M; i++) begin
            t[2*i] = a[i];
        end
        for (int i = 2*GF_M-2; i >= GF_M; i--) begin
            if (t[i]) begin
                t[i-GF_M]      = ~t[i-GF_M];
                t[i-GF_M+GF_K] = ~t[i-GF_M+GF_K];
            end
        end
        return t[GF_M-1:0];
    endfunction

endpackage

// File: rtl/gf233_sqr.sv
// Combinational GF(2^233) squarer, shared by the multiplier-side datapath and the
// iterative square-root unit.
module gf233_sqr
    import gf233_pkg::*;
(
    input  gf233_t a,
    output gf233_t y
);

    assign y = gf233_sqr_f(a);

endmodule

// File: rtl/gf233_sqrt_iter.sv
// Iterative GF(2^233) square root: sqrt(a) = a^(2^232), applied as SQ_PER_CYCLE
// chained squarings per clock over 232/SQ_PER_CYCLE cycles.
module gf233_sqrt_iter
    import gf233_pkg::*;
#(
    parameter int SQ_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  gf233_t din,
    output logic   busy,
    output logic   done,
    output gf233_t dout
);

    localparam int         N_ITER   = GF_SQRT_EXP / SQ_PER_CYCLE;
    localparam logic [7:0] CNT_LOAD = 8'(N_ITER - 1);

    generate
        if (!(SQ_PER_CYCLE == 1 || SQ_PER_CYCLE == 2 ||
              SQ_PER_CYCLE == 4 || SQ_PER_CYCLE == 8)) begin : g_bad_sq_per_cycle
            $error("gf233_sqrt_iter: SQ_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    sqrt_state_e state_r, state_nx_s;
    logic [7:0]  cnt_r, cnt_nx_s;
    gf233_t      acc_r, acc_nx_s;
    logic        done_r, done_nx_s;

    gf233_t      chain_s [SQ_PER_CYCLE+1];

    assign chain_s[0] = acc_r;

    generate
        for (genvar i = 0; i < SQ_PER_CYCLE; i++) begin : g_sqr_chain
            gf233_sqr u_sqr (
                .a (chain_s[i]),
                .y (chain_s[i+1])
            );
        end
    endgenerate

    // Next-state, counter and accumulator update; done only pulses on the final iteration.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        acc_nx_s   = acc_r;
        done_nx_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_nx_s   = din;
                    cnt_nx_s   = CNT_LOAD;
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_nx_s = chain_s[SQ_PER_CYCLE];
                if (cnt_r == 8'd0) begin
                    state_nx_s = ST_IDLE;
                    done_nx_s  = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
            acc_r   <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            acc_r   <= acc_nx_s;
            done_r  <= done_nx_s;
        end
    end

    assign busy = (state_r == ST_RUN);
    assign done = done_r;
    assign dout = acc_r;

endmodule
